// File: rtl/button_conditioner.sv
// Button conditioner: synchronises a divided sample clock and raw buttons,
// debounces each button and emits press and auto-repeat pulses.
module button_conditioner #(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned DEB_LEN   = 4,
  parameter logic [7:0]  REP_DELAY = 8'd30,
  parameter logic [7:0]  REP_RATE  = 8'd6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk,
  input  logic [N_BTN-1:0] btn_in,
  output logic             div_tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  typedef enum logic [1:0] {RELEASED, HELD, REPEAT} state_e;

  logic               div_s1_q, div_s2_q, div_s3_q, div_tick_q;
  logic [N_BTN-1:0]   btn_s1_q, btn_s2_q;
  logic [DEB_LEN-1:0] shreg_q [N_BTN];
  logic [DEB_LEN-1:0] shreg_d [N_BTN];
  logic [N_BTN-1:0]   level_q, level_d;
  logic [N_BTN-1:0]   pulse_q, pulse_d;
  state_e             state_q [N_BTN];
  state_e             state_d [N_BTN];
  logic [7:0]         cnt_q   [N_BTN];
  logic [7:0]         cnt_d   [N_BTN];
  logic [7:0]         cnt_inc [N_BTN];
  logic [N_BTN-1:0]   rise, fall, adv, match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_s1_q   <= 1'b0;
      div_s2_q   <= 1'b0;
      div_s3_q   <= 1'b0;
      div_tick_q <= 1'b0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
    end else begin
      div_s1_q   <= div_clk;
      div_s2_q   <= div_s1_q;
      div_s3_q   <= div_s2_q;
      div_tick_q <= div_s2_q & ~div_s3_q;
      btn_s1_q   <= btn_in;
      btn_s2_q   <= btn_s1_q;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      shreg_d[i] = shreg_q[i];
      if (div_tick_q) shreg_d[i] = {shreg_q[i][DEB_LEN-2:0], btn_s2_q[i]};
      level_d[i] = level_q[i];
      if (&shreg_q[i])            level_d[i] = 1'b1;
      else if (shreg_q[i] == '0)  level_d[i] = 1'b0;
      rise[i] = level_d[i] & ~level_q[i];
      fall[i] = ~level_d[i] & level_q[i];
      // A tick that completes the release debounce must not advance or fire the
      // timer, so a release coinciding with a repeat match stays silent.
      adv[i]     = div_tick_q & (shreg_d[i] != '0);
      cnt_inc[i] = (cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1;
      case (state_q[i])
        HELD:    match[i] = adv[i] & (REP_DELAY != 8'd0) & (cnt_inc[i] == REP_DELAY);
        REPEAT:  match[i] = adv[i] & (cnt_inc[i] == REP_RATE);
        default: match[i] = 1'b0;
      endcase
      match[i] = match[i] & ~fall[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        shreg_q[i] <= '0;
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        shreg_q[i] <= shreg_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RELEASED: begin
          if (rise[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end
        end
        HELD, REPEAT: begin
          if (fall[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (match[i]) begin
            state_d[i] = REPEAT;
            cnt_d[i]   = '0;
          end else if (adv[i]) begin
            cnt_d[i]   = cnt_inc[i];
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      pulse_d[i] = ((state_q[i] == RELEASED) & rise[i]) | match[i];
    end
  end

  assign div_tick  = div_tick_q;
  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule
